// File: rtl/clockgen_prog.sv
// Programmable two-phase clock generator for the emulated i4004 system.
// Run/stop/single-step control with boundary-synchronised timing updates.
module clockgen_prog #(
    parameter int SYSCLK_TCY   = 20,
    parameter int EXT_CLK_PROP = 0,
    parameter int CW           = 8,
    parameter int RUN_AT_RESET = 1
) (
    input  logic          sysclk,
    input  logic          sysreset,
    input  logic          run,
    input  logic          step,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_tpw,
    input  logic [CW-1:0] cfg_td1,
    input  logic [CW-1:0] cfg_td2,
    output logic          cfg_err,
    output logic          cfg_pending,
    output logic          clk1,
    output logic          clk2,
    output logic          clk1_ext,
    output logic          clk2_ext,
    output logic          cycle_start,
    output logic          running
);

    localparam int PW = CW + 2;
    localparam logic [CW-1:0] DEF_TPW = CW'(400 / SYSCLK_TCY);
    localparam logic [CW-1:0] DEF_TD1 = CW'(400 / SYSCLK_TCY);
    localparam logic [CW-1:0] DEF_TD2 = CW'(200 / SYSCLK_TCY);
    localparam logic [CW:0]   EXT_W   = (CW+1)'(EXT_CLK_PROP);
    localparam logic [PW:0]   EXT_C   = (PW+1)'(EXT_CLK_PROP);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUN,
        ST_STEP
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tpw_q, td1_q, td2_q;
    logic [CW-1:0] sh_tpw_q, sh_td1_q, sh_td2_q;
    logic          pend_q, err_q;
    logic          clk1_q, clk2_q, clk1e_q, clk2e_q, cs_q;

    logic [PW-1:0] tpw_w, td1_w, td2_w;
    logic [PW-1:0] per_w, e2_w, e3_w;
    logic [PW:0]   cnt_e;
    logic          active, wrap, boundary;
    logic          cfg_ok, we_ok;
    logic          in_w1, in_w2, ext_w1, ext_w2;

    assign tpw_w = {2'b00, tpw_q};
    assign td1_w = {2'b00, td1_q};
    assign td2_w = {2'b00, td2_q};
    assign per_w = td2_w + tpw_w + td1_w + tpw_w;
    assign e2_w  = td2_w + tpw_w;
    assign e3_w  = e2_w + td1_w;

    assign active   = (state_q != ST_STOPPED);
    assign wrap     = active && (cnt_q == per_w - PW'(1));
    assign boundary = wrap || !active;

    assign cfg_ok = (cfg_tpw != '0) && (cfg_td1 != '0) && (cfg_td2 != '0)
                 && ({1'b0, cfg_td2} >= EXT_W);
    assign we_ok  = cfg_we && cfg_ok;

    assign in_w1 = (cnt_q >= td2_w) && (cnt_q < e2_w);
    assign in_w2 = (cnt_q >= e3_w) && (cnt_q < per_w);

    // Ext decode looks ahead; TD2 >= EXT_CLK_PROP keeps it from wrapping.
    assign cnt_e  = {1'b0, cnt_q} + EXT_C;
    assign ext_w1 = (cnt_e >= {1'b0, td2_w}) && (cnt_e < {1'b0, e2_w});
    assign ext_w2 = (cnt_e >= {1'b0, e3_w}) && (cnt_e < {1'b0, per_w});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (wrap) begin
                    state_d = run ? ST_RUN : ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (active && !wrap) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q <= (RUN_AT_RESET != 0) ? ST_RUN : ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            cnt_q    <= '0;
            tpw_q    <= DEF_TPW;
            td1_q    <= DEF_TD1;
            td2_q    <= DEF_TD2;
            sh_tpw_q <= DEF_TPW;
            sh_td1_q <= DEF_TD1;
            sh_td2_q <= DEF_TD2;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            clk1_q   <= 1'b0;
            clk2_q   <= 1'b0;
            clk1e_q  <= 1'b0;
            clk2e_q  <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= cfg_we && !cfg_ok;
            clk1_q  <= active && in_w1;
            clk2_q  <= active && in_w2;
            clk1e_q <= active && ext_w1;
            clk2e_q <= active && ext_w2;
            cs_q    <= active && (cnt_q == '0);
            // A write on a boundary edge waits in shadow for the next one.
            if (boundary) begin
                tpw_q  <= sh_tpw_q;
                td1_q  <= sh_td1_q;
                td2_q  <= sh_td2_q;
                pend_q <= we_ok;
            end else if (we_ok) begin
                pend_q <= 1'b1;
            end
            if (we_ok) begin
                sh_tpw_q <= cfg_tpw;
                sh_td1_q <= cfg_td1;
                sh_td2_q <= cfg_td2;
            end
        end
    end

    assign cfg_err     = err_q;
    assign cfg_pending = pend_q;
    assign clk1        = clk1_q;
    assign clk2        = clk2_q;
    assign clk1_ext    = clk1e_q;
    assign clk2_ext    = clk2e_q;
    assign cycle_start = cs_q;
    assign running     = active;

endmodule

// File: tb/tb_clockgen_prog.sv
// Directed bench for clockgen_prog: two instances, EXT_CLK_PROP 0 and 3,
// share one stimulus and are compared against hand-computed timelines.
module tb_clockgen_prog;

    localparam int CW = 8;

    logic          sysclk = 1'b0;
    logic          sysreset = 1'b1;
    logic          run = 1'b1;
    logic          step = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_tpw = '0;
    logic [CW-1:0] cfg_td1 = '0;
    logic [CW-1:0] cfg_td2 = '0;

    logic a_err, a_pend, a_clk1, a_clk2, a_c1e, a_c2e, a_cs, a_run;
    logic b_err, b_pend, b_clk1, b_clk2, b_c1e, b_c2e, b_cs, b_run;

    always #5 sysclk = ~sysclk;

    clockgen_prog #(.SYSCLK_TCY(20), .EXT_CLK_PROP(0), .CW(CW), .RUN_AT_RESET(1)) u0 (
        .sysclk(sysclk), .sysreset(sysreset), .run(run), .step(step),
        .cfg_we(cfg_we), .cfg_tpw(cfg_tpw), .cfg_td1(cfg_td1), .cfg_td2(cfg_td2),
        .cfg_err(a_err), .cfg_pending(a_pend), .clk1(a_clk1), .clk2(a_clk2),
        .clk1_ext(a_c1e), .clk2_ext(a_c2e), .cycle_start(a_cs), .running(a_run)
    );

    clockgen_prog #(.SYSCLK_TCY(20), .EXT_CLK_PROP(3), .CW(CW), .RUN_AT_RESET(1)) u3 (
        .sysclk(sysclk), .sysreset(sysreset), .run(run), .step(step),
        .cfg_we(cfg_we), .cfg_tpw(cfg_tpw), .cfg_td1(cfg_td1), .cfg_td2(cfg_td2),
        .cfg_err(b_err), .cfg_pending(b_pend), .clk1(b_clk1), .clk2(b_clk2),
        .clk1_ext(b_c1e), .clk2_ext(b_c2e), .cycle_start(b_cs), .running(b_run)
    );

    // Expected values after edge t for the EXT_CLK_PROP=3 instance;
    // the EXT_CLK_PROP=0 instance must show c1/c2 on its ext outputs too.
    typedef struct {
        int   t;
        logic c1;
        logic c2;
        logic c1e;
        logic c2e;
        logic cs;
    } vec_t;

    vec_t tab[$];
    int   t;
    int   errors;
    int   checks;

    function automatic vec_t v(input int tt, input logic [4:0] b);
        vec_t r;
        r.t   = tt;
        r.c1  = b[4];
        r.c2  = b[3];
        r.c1e = b[2];
        r.c2e = b[1];
        r.cs  = b[0];
        return r;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
        t++;
    endtask

    task automatic tick_to(input int target);
        while (t < target) tick();
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
        end
    endtask

    task automatic apply_table();
        foreach (tab[i]) begin
            tick_to(tab[i].t);
            check("u3.clk1", b_clk1, tab[i].c1);
            check("u3.clk2", b_clk2, tab[i].c2);
            check("u3.clk1_ext", b_c1e, tab[i].c1e);
            check("u3.clk2_ext", b_c2e, tab[i].c2e);
            check("u3.cycle_start", b_cs, tab[i].cs);
            check("u0.clk1", a_clk1, tab[i].c1);
            check("u0.clk2", a_clk2, tab[i].c2);
            check("u0.clk1_ext", a_c1e, tab[i].c1);
            check("u0.clk2_ext", a_c2e, tab[i].c2);
            check("u0.cycle_start", a_cs, tab[i].cs);
        end
    endtask

    // Default timing 20/20/10: W1=[10,30), W2=[50,70), ext windows 3 earlier.
    task automatic load_default_table();
        tab.delete();
        tab.push_back(v(0,  5'b00000));
        tab.push_back(v(1,  5'b00001));
        tab.push_back(v(2,  5'b00000));
        tab.push_back(v(7,  5'b00000));
        tab.push_back(v(8,  5'b00100));
        tab.push_back(v(10, 5'b00100));
        tab.push_back(v(11, 5'b10100));
        tab.push_back(v(26, 5'b10100));
        tab.push_back(v(27, 5'b10100));
        tab.push_back(v(28, 5'b10000));
        tab.push_back(v(30, 5'b10000));
        tab.push_back(v(31, 5'b00000));
        tab.push_back(v(47, 5'b00000));
        tab.push_back(v(48, 5'b00010));
        tab.push_back(v(50, 5'b00010));
        tab.push_back(v(51, 5'b01010));
        tab.push_back(v(67, 5'b01010));
        tab.push_back(v(68, 5'b01000));
        tab.push_back(v(70, 5'b01000));
        tab.push_back(v(71, 5'b00001));
        tab.push_back(v(72, 5'b00000));
        tab.push_back(v(81, 5'b10100));
    endtask

    int n_c1r, n_c2r, n_c1h, n_c2h, n_csb, n_csa;
    logic p1, p2;
    bit seen;

    initial begin
        errors = 0;
        checks = 0;
        t = 0;

        // Reset, free-run with default timing
        tick();
        tick();
        t = 0;
        sysreset = 1'b0;
        check("rst.running_u3", b_run, 1'b1);
        check("rst.running_u0", a_run, 1'b1);
        check("rst.pending", b_pend, 1'b0);
        check("rst.err", b_err, 1'b0);
        load_default_table();
        apply_table();

        // 5/5/5 written mid-cycle: 70-cycle period finishes first
        cfg_tpw = 8'd5;
        cfg_td1 = 8'd5;
        cfg_td2 = 8'd5;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        check("cfg555.pending_u3", b_pend, 1'b1);
        check("cfg555.pending_u0", a_pend, 1'b1);
        check("cfg555.err", b_err, 1'b0);
        tick_to(139);
        check("cfg555.pending_held", b_pend, 1'b1);
        tick_to(140);
        check("cfg555.pending_clr", b_pend, 1'b0);
        tab.delete();
        tab.push_back(v(140, 5'b01000));
        tab.push_back(v(141, 5'b00001));
        tab.push_back(v(142, 5'b00000));
        tab.push_back(v(143, 5'b00100));
        tab.push_back(v(146, 5'b10100));
        tab.push_back(v(147, 5'b10100));
        tab.push_back(v(148, 5'b10000));
        tab.push_back(v(150, 5'b10000));
        tab.push_back(v(151, 5'b00000));
        tab.push_back(v(153, 5'b00010));
        tab.push_back(v(156, 5'b01010));
        tab.push_back(v(157, 5'b01010));
        tab.push_back(v(158, 5'b01000));
        tab.push_back(v(160, 5'b01000));
        tab.push_back(v(161, 5'b00001));
        apply_table();

        // Zero field rejected, timing stays at period 20
        cfg_tpw = 8'd0;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        check("bad0.err_u3", b_err, 1'b1);
        check("bad0.err_u0", a_err, 1'b1);
        check("bad0.pending_u3", b_pend, 1'b0);
        check("bad0.pending_u0", a_pend, 1'b0);
        tick();
        check("bad0.err_pulse", b_err, 1'b0);
        tick_to(181);
        check("bad0.period_u3", b_cs, 1'b1);
        check("bad0.period_u0", a_cs, 1'b1);

        // Restore 20/20/10, then drop run at cnt=30
        cfg_tpw = 8'd20;
        cfg_td1 = 8'd20;
        cfg_td2 = 8'd10;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        check("restore.pending", b_pend, 1'b1);
        tick_to(201);
        check("restore.cs", b_cs, 1'b1);
        check("restore.pending_clr", b_pend, 1'b0);
        tick_to(230);
        run = 1'b0;
        tick_to(269);
        check("stop.running_269", b_run, 1'b1);
        check("stop.clk2_269", b_clk2, 1'b1);
        tick_to(270);
        check("stop.running_270", b_run, 1'b0);
        check("stop.running_270_u0", a_run, 1'b0);
        check("stop.clk2_270", b_clk2, 1'b1);
        tick_to(271);
        check("stop.clk1_low", b_clk1, 1'b0);
        check("stop.clk2_low", b_clk2, 1'b0);
        n_csb = 0;
        while (t < 290) begin
            tick();
            if (b_cs || a_cs || b_clk1 || b_clk2) n_csb++;
        end
        check_int("stop.idle_activity", n_csb, 0);

        // Single step, with an ignored second step pulse mid-cycle
        step = 1'b1;
        tick();
        step = 1'b0;
        n_c1r = 0; n_c2r = 0; n_c1h = 0; n_c2h = 0; n_csb = 0; n_csa = 0;
        p1 = 1'b0;
        p2 = 1'b0;
        while (1) begin
            if (b_clk1 && !p1) n_c1r++;
            if (b_clk2 && !p2) n_c2r++;
            if (b_clk1) n_c1h++;
            if (b_clk2) n_c2h++;
            if (b_cs) n_csb++;
            if (a_cs) n_csa++;
            p1 = b_clk1;
            p2 = b_clk2;
            if (t >= 441) break;
            if (t == 310) step = 1'b1;
            tick();
            step = 1'b0;
        end
        check_int("step.clk1_pulses", n_c1r, 1);
        check_int("step.clk2_pulses", n_c2r, 1);
        check_int("step.clk1_width", n_c1h, 20);
        check_int("step.clk2_width", n_c2h, 20);
        check_int("step.cycle_start_u3", n_csb, 1);
        check_int("step.cycle_start_u0", n_csa, 1);
        check("step.stopped", b_run, 1'b0);

        // Resume; td2=2 is below EXT_CLK_PROP=3 only for u3
        run = 1'b1;
        tick();
        cfg_tpw = 8'd20;
        cfg_td1 = 8'd20;
        cfg_td2 = 8'd2;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        check("td2.err_u3", b_err, 1'b1);
        check("td2.pending_u3", b_pend, 1'b0);
        check("td2.err_u0", a_err, 1'b0);
        check("td2.pending_u0", a_pend, 1'b1);
        check("resume.cs", b_cs, 1'b1);

        // Reset while clk2 is high
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_clk2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("rst2.clk2_seen", seen, 1'b1);
        sysreset = 1'b1;
        tick();
        check("rst2.clk1_u3", b_clk1, 1'b0);
        check("rst2.clk2_u3", b_clk2, 1'b0);
        check("rst2.clk1_ext_u3", b_c1e, 1'b0);
        check("rst2.clk2_ext_u3", b_c2e, 1'b0);
        check("rst2.clk2_u0", a_clk2, 1'b0);
        check("rst2.pending_u0", a_pend, 1'b0);
        check("rst2.running_u3", b_run, 1'b1);
        sysreset = 1'b0;
        t = 0;
        load_default_table();
        apply_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
        $fatal(1, "watchdog");
    end

endmodule
